// File: rtl/fir_out_collector.sv
// FIR output collector: frame-capture FSM feeding a first-word fall-through sample FIFO.
// Optional macro FIR_COLLECT_PEAK_EN adds a PEAK output that tracks the largest |DIN| stored in the frame.
`timescale 1ns/1ps
module fir_out_collector #(
  parameter int DATA_WIDTH = 13,
  parameter int DEPTH      = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         VIN,
  input  logic signed [DATA_WIDTH-1:0] DIN,
  input  logic                         START,
  input  logic [7:0]                   FRAME_LEN,
  output logic                         RD_VALID,
  input  logic                         RD_READY,
  output logic signed [DATA_WIDTH-1:0] RD_DATA,
  output logic [$clog2(DEPTH):0]       COUNT,
  output logic                         FULL,
  output logic                         EMPTY,
  output logic                         OVF,
  input  logic                         OVF_CLR,
  output logic                         BUSY,
  output logic                         DONE,
`ifdef FIR_COLLECT_PEAK_EN
  output logic [DATA_WIDTH-1:0]        PEAK,
`endif
  output logic [7:0]                   SAMPLE_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t                       state, state_n;
  logic [7:0]                   frame_len, frame_len_n;
  logic [7:0]                   sample_cnt, sample_cnt_n;
  logic [7:0]                   cnt_eff, len_eff;
  logic                         in_cap;

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [AW:0]                  count;
  logic                         push_req, push, pop, drop;

  assign EMPTY      = (count == '0);
  assign FULL       = (count == FULL_CNT);
  assign COUNT      = count;
  assign RD_VALID   = !EMPTY;
  assign RD_DATA    = mem[rd_ptr];
  assign BUSY       = (state == S_CAPTURE);
  assign DONE       = (state == S_DONE);
  assign SAMPLE_CNT = sample_cnt;

  // START re-arms the frame in the same cycle, so a coincident VIN counts as sample 0
  assign in_cap   = START || (state == S_CAPTURE);
  assign cnt_eff  = START ? 8'd0 : sample_cnt;
  assign len_eff  = START ? FRAME_LEN : frame_len;

  assign pop      = RD_VALID && RD_READY;
  assign push_req = in_cap && VIN;
  assign push     = push_req && (!FULL || pop);
  assign drop     = push_req && !push;

  always_comb begin
    state_n      = state;
    frame_len_n  = len_eff;
    sample_cnt_n = cnt_eff;
    if (START) state_n = S_CAPTURE;
    if (push_req) begin
      sample_cnt_n = cnt_eff + 8'd1;
      if ((len_eff != 8'd0) && (cnt_eff == len_eff - 8'd1)) state_n = S_DONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      frame_len  <= 8'd0;
      sample_cnt <= 8'd0;
      OVF        <= 1'b0;
    end else begin
      state      <= state_n;
      frame_len  <= frame_len_n;
      sample_cnt <= sample_cnt_n;
      if (drop)         OVF <= 1'b1;
      else if (OVF_CLR) OVF <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= DIN;
  end

`ifdef FIR_COLLECT_PEAK_EN
  function automatic logic [DATA_WIDTH-1:0] abs_mag(input logic signed [DATA_WIDTH-1:0] x);
    // the most negative value wraps to its own bit pattern, which read unsigned is its magnitude
    return x[DATA_WIDTH-1] ? DATA_WIDTH'(-x) : DATA_WIDTH'(x);
  endfunction

  logic [DATA_WIDTH-1:0] abs_p0;
  logic                  vld_p0;

  // stage p0: magnitude of the stored sample
  always_ff @(posedge CLK) begin
    abs_p0 <= abs_mag(DIN);
  end

  // stage p1: running maximum
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p0 <= 1'b0;
      PEAK   <= '0;
    end else begin
      vld_p0 <= push;
      if (START)                         PEAK <= '0;
      else if (vld_p0 && abs_p0 > PEAK)  PEAK <= abs_p0;
    end
  end
`endif

endmodule

// File: tb/tb_fir_out_collector.sv
// Directed self-checking bench for fir_out_collector (default DATA_WIDTH=13, DEPTH=16).
`timescale 1ns/1ps
module tb_fir_out_collector;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               VIN = 1'b0;
  logic signed [12:0] DIN = '0;
  logic               START = 1'b0;
  logic [7:0]         FRAME_LEN = '0;
  logic               RD_VALID;
  logic               RD_READY = 1'b0;
  logic signed [12:0] RD_DATA;
  logic [4:0]         COUNT;
  logic               FULL, EMPTY, OVF, BUSY, DONE;
  logic               OVF_CLR = 1'b0;
  logic [7:0]         SAMPLE_CNT;
`ifdef FIR_COLLECT_PEAK_EN
  logic [12:0]        PEAK;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fir_out_collector dut (
    .CLK(CLK), .RST(RST), .VIN(VIN), .DIN(DIN), .START(START), .FRAME_LEN(FRAME_LEN),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA), .COUNT(COUNT),
    .FULL(FULL), .EMPTY(EMPTY), .OVF(OVF), .OVF_CLR(OVF_CLR), .BUSY(BUSY), .DONE(DONE),
`ifdef FIR_COLLECT_PEAK_EN
    .PEAK(PEAK),
`endif
    .SAMPLE_CNT(SAMPLE_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic sample(input int v);
    VIN = 1'b1;
    DIN = 13'(v);
    tick();
    VIN = 1'b0;
  endtask

  initial begin
    int exp_rd [4];
    exp_rd = '{5, -3, 100, -4096};

    // reset state
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    check("rst_count", COUNT, 0);
    check("rst_empty", EMPTY, 1);
    check("rst_full", FULL, 0);
    check("rst_rd_valid", RD_VALID, 0);
    check("rst_ovf", OVF, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_sample_cnt", SAMPLE_CNT, 0);

    // idle ignores VIN
    sample(33);
    check("idle_vin_ignored", COUNT, 0);

    // four-sample frame
    FRAME_LEN = 8'd4; START = 1'b1; tick(); START = 1'b0;
    check("f4_busy", BUSY, 1);
    check("f4_cnt0", SAMPLE_CNT, 0);
    sample(5);
    check("f4_latency_valid", RD_VALID, 1);
    check("f4_latency_data", RD_DATA, 5);
    sample(-3); sample(100); sample(-4096);
    check("f4_count", COUNT, 4);
    check("f4_done", DONE, 1);
    check("f4_busy_off", BUSY, 0);
    check("f4_sample_cnt", SAMPLE_CNT, 4);
    sample(9);
    check("done_vin_ignored", COUNT, 4);
    RD_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("f4_read%0d", i), RD_DATA, exp_rd[i]);
      tick();
    end
    RD_READY = 1'b0;
    check("f4_drained", EMPTY, 1);

    // continuous capture overflowing the FIFO
    FRAME_LEN = 8'd0; START = 1'b1; tick(); START = 1'b0;
    for (int i = 1; i <= 16; i++) sample(i);
    check("c_full16", FULL, 1);
    check("c_ovf_before_drop", OVF, 0);
    for (int i = 17; i <= 20; i++) sample(i);
    check("c_ovf", OVF, 1);
    check("c_sample_cnt", SAMPLE_CNT, 20);
    check("c_count", COUNT, 16);
    check("c_busy", BUSY, 1);
    check("c_first", RD_DATA, 1);

    // overflow clear versus coincident drop
    OVF_CLR = 1'b1; tick();
    check("ovf_clr", OVF, 0);
    VIN = 1'b1; DIN = 13'sd50; tick(); VIN = 1'b0;
    check("ovf_drop_wins", OVF, 1);
    tick(); OVF_CLR = 1'b0;
    check("ovf_clr_alone", OVF, 0);

    // push and pop together at full
    RD_READY = 1'b1;
    sample(7);
    check("pp_count", COUNT, 16);
    check("pp_ovf", OVF, 0);
    check("pp_sample_cnt", SAMPLE_CNT, 22);
    for (int i = 2; i <= 16; i++) begin
      check($sformatf("pp_read%0d", i), RD_DATA, i);
      tick();
    end
    check("pp_last7", RD_DATA, 7);
    tick();
    RD_READY = 1'b0;
    check("pp_empty", EMPTY, 1);

    // START with VIN, then restart inside CAPTURE keeps FIFO
    FRAME_LEN = 8'd2; START = 1'b1; VIN = 1'b1; DIN = -13'sd1; tick();
    START = 1'b0; VIN = 1'b0;
    check("sv_cnt", SAMPLE_CNT, 1);
    check("sv_count", COUNT, 1);
    check("sv_data", RD_DATA, -1);
    FRAME_LEN = 8'd3; START = 1'b1; tick(); START = 1'b0;
    check("restart_cnt", SAMPLE_CNT, 0);
    check("restart_keep", COUNT, 1);
    sample(-2); sample(3);
    check("restart_busy", BUSY, 1);
    sample(-4);
    check("restart_done", DONE, 1);
    check("restart_count", COUNT, 4);
    RD_READY = 1'b1;
    check("restart_rd0", RD_DATA, -1); tick();
    check("restart_rd1", RD_DATA, -2); tick();
    check("restart_rd2", RD_DATA, 3); tick();
    check("restart_rd3", RD_DATA, -4); tick();
    RD_READY = 1'b0;

    // reset mid-frame
    FRAME_LEN = 8'd10; START = 1'b1; tick(); START = 1'b0;
    sample(11); sample(12);
    VIN = 1'b1; DIN = 13'sd13; RST = 1'b1; tick(); RST = 1'b0; VIN = 1'b0;
    check("mr_empty", EMPTY, 1);
    check("mr_busy", BUSY, 0);
    check("mr_done", DONE, 0);
    check("mr_sample_cnt", SAMPLE_CNT, 0);
    sample(14);
    check("mr_vin_ignored", EMPTY, 1);
    check("mr_cnt_after", SAMPLE_CNT, 0);

`ifdef FIR_COLLECT_PEAK_EN
    FRAME_LEN = 8'd0; START = 1'b1; tick(); START = 1'b0;
    check("pk_start", PEAK, 0);
    sample(-4096);
    check("pk_lag", PEAK, 0);
    sample(2000); sample(12); tick();
    check("pk_max", PEAK, 4096);
    START = 1'b1; tick(); START = 1'b0;
    check("pk_cleared", PEAK, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
